wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 108 ++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results and loads, waits on late load data,
// and flags decode hazards against every destination still in flight.
module wb_stage #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        MEM_WB_EN_in,
  input  logic        MEM_R_EN_in,
  input  logic [3:0]  Dest_in,
  input  logic [31:0] ALU_Res_in,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_valid,
  input  logic        id_valid,
  input  logic [3:0]  id_Rn,
  input  logic [3:0]  id_src2,
  input  logic        id_two_src,
  output logic        WB_WB_EN,
  output logic [3:0]  WB_Dest,
  output logic [31:0] WB_Value,
  output logic        Hazard,
  output logic        wb_stall,
  output logic        load_timeout,
  output logic [15:0] retire_count
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOAD,
    WRITE
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [3:0]    pend_dest;
  logic          accept;
  logic          hit_mem;
  logic          hit_wait;
  logic          hit_wr;

  assign accept   = (state != WAIT_LOAD) & mem_valid & MEM_WB_EN_in;
  assign wb_stall = (state == WAIT_LOAD);

  assign hit_mem  = mem_valid & MEM_WB_EN_in &
                    ((id_Rn == Dest_in) |
                     (id_two_src & (id_src2 == Dest_in)));
  assign hit_wait = (state == WAIT_LOAD) &
                    ((id_Rn == pend_dest) |
                     (id_two_src & (id_src2 == pend_dest)));
  assign hit_wr   = (state == WRITE) &
                    ((id_Rn == WB_Dest) |
                     (id_two_src & (id_src2 == WB_Dest)));
  assign Hazard   = id_valid & (hit_mem | hit_wait | hit_wr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      pend_dest    <= '0;
      WB_WB_EN     <= 1'b0;
      WB_Dest      <= '0;
      WB_Value     <= '0;
      load_timeout <= 1'b0;
      retire_count <= '0;
    end else begin
      WB_WB_EN <= 1'b0;
      unique case (state)
        IDLE, WRITE: begin
          state <= IDLE;
          if (accept) begin
            if (!MEM_R_EN_in || mem_rdata_valid) begin
              state        <= WRITE;
              WB_WB_EN     <= 1'b1;
              WB_Dest      <= Dest_in;
              WB_Value     <= MEM_R_EN_in ? mem_rdata : ALU_Res_in;
              retire_count <= retire_count + 16'd1;
            end else begin
              state     <= WAIT_LOAD;
              pend_dest <= Dest_in;
              wait_cnt  <= '0;
            end
          end
        end
        WAIT_LOAD: begin
          // late data beats the timeout on the very last wait cycle
          if (mem_rdata_valid) begin
            state        <= WRITE;
            WB_WB_EN     <= 1'b1;
            WB_Dest      <= pend_dest;
            WB_Value     <= mem_rdata;
            retire_count <= retire_count + 16'd1;
          end else if (wait_cnt == TMO) begin
            state        <= IDLE;
            load_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
